// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for the RV32IM EX stage.
// Retires one product bit per cycle. Signed operands are reduced to magnitudes
// at accept, and the sign is applied in a single fix-up cycle at the end.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            mul_done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [XLEN:0]     acc;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   mcand;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [1:0]        ctl;

  logic              accept;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] fixed;

  // Operand conditioning at accept, plus the add and the sign fix-up of the datapath.
  always_comb begin
    accept  = 1'b0;
    sign_a  = rs1[XLEN-1] & ((mulctl == 2'b01) | (mulctl == 2'b10));
    sign_b  = rs2[XLEN-1] & (mulctl == 2'b01);
    mag_a   = sign_a ? -rs1 : rs1;
    mag_b   = sign_b ? -rs2 : rs2;
    addend  = mplier[0] ? mcand : '0;
    sum     = acc + {1'b0, addend};
    product = {acc[XLEN-1:0], mplier};
    fixed   = neg ? -product : product;
    if ((state == IDLE || state == DONE) && start && !flush) begin
      accept = 1'b1;
    end
  end

  // State register; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Flush wins over everything, including a start in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = CALC;
      end
      CALC: begin
        if (flush)                 state_next = IDLE;
        else if (cnt == CNT_LAST)  state_next = FIX;
      end
      FIX: begin
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        state_next = accept ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode directly from the state.
  always_comb begin
    busy     = (state == CALC) || (state == FIX);
    mul_done = (state == DONE);
  end

  // Datapath: latch operands on accept, shift-add in CALC, and write the result only in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      ctl    <= 2'b00;
      result <= '0;
    end else if (accept) begin
      acc    <= '0;
      mplier <= mag_b;
      mcand  <= mag_a;
      cnt    <= '0;
      neg    <= sign_a ^ sign_b;
      ctl    <= mulctl;
    end else if (state == CALC && !flush) begin
      acc    <= {1'b0, sum[XLEN:1]};
      mplier <= {sum[0], mplier[XLEN-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end else if (state == FIX && !flush) begin
      result <= (ctl == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed protocol steps plus randomized
// operands compared against a plain 64-bit arithmetic reference.
module tb_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mulctl;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        mul_done;
  logic [31:0] result;

  int          total;
  int          bad;
  logic [31:0] last_res;

  mul_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mulctl   (mulctl),
    .rs1      (rs1),
    .rs2      (rs2),
    .flush    (flush),
    .busy     (busy),
    .mul_done (mul_done),
    .result   (result)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend each operand by its signedness, multiply mod 2^64, pick a half.
  function automatic logic [31:0] ref_mul(input logic [1:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (ctl == 2'b01 || ctl == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (ctl == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (ctl == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1 with inputs scrambled.
  task automatic launch(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mulctl = ctl;
    rs1    = a;
    rs2    = b;
    @(negedge clk);
    start  = 1'b0;
    mulctl = 2'($urandom_range(3));
    rs1    = $urandom;
    rs2    = $urandom;
  endtask

  // From the negedge of cycle 1, count cycles until mul_done (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!mul_done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Count mul_done pulses over a fixed window with start held low.
  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mul_done) n++;
    end
  endtask

  // One full operation: launch, wait, check latency, result and single-cycle pulse.
  task automatic applyStimulus(input string tag, input logic [1:0] ctl,
                               input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] exp;
    exp = ref_mul(ctl, a, b);
    @(negedge clk);
    launch(ctl, a, b);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd34);
    checkOutput({tag, "_res"}, result, exp);
    last_res = exp;
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(mul_done), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int done_cyc;
    logic [31:0] done_res;
    logic [31:0] exp;
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    total    = 0;
    bad      = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    mulctl   = 2'b00;
    rs1      = 32'd0;
    rs2      = 32'd0;

    // Reset state.
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(mul_done), 32'd0);
    checkOutput("rst_res", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    applyStimulus("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mul_7_m3_const", last_res, 32'hFFFF_FFEB);
    applyStimulus("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000);
    checkOutput("mulh_min_const", last_res, 32'h4000_0000);
    applyStimulus("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mulhu_max_const", last_res, 32'hFFFF_FFFE);
    applyStimulus("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mulhsu_m1_const", last_res, 32'hFFFF_FFFF);
    applyStimulus("mulh_m1_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
    checkOutput("mulh_m1_1_const", last_res, 32'hFFFF_FFFF);
    applyStimulus("mul_zero", 2'b00, 32'd0, 32'h1234_5678);
    applyStimulus("mulhsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // Starts at cycles 5 and 20 are ignored; exactly one done at cycle 34.
    @(negedge clk);
    exp = ref_mul(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    launch(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    n = 0;
    done_cyc = 0;
    done_res = 32'd0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (mul_done) begin
        n++;
        done_cyc = cyc;
        done_res = result;
      end
      start = (cyc == 5 || cyc == 20);
      if (start) begin
        mulctl = 2'($urandom_range(3));
        rs1    = $urandom;
        rs2    = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ign_count", 32'(n), 32'd1);
    checkOutput("ign_cycle", 32'(done_cyc), 32'd34);
    checkOutput("ign_res", done_res, exp);
    last_res = exp;

    // Start during the DONE cycle is accepted back-to-back.
    @(negedge clk);
    launch(2'b00, 32'd100, 32'd200);
    wait_done(lat);
    checkOutput("b2b_first", result, 32'd20000);
    launch(2'b11, 32'hF000_0000, 32'h0000_0100);
    wait_done(lat);
    checkOutput("b2b_lat", 32'(lat), 32'd34);
    checkOutput("b2b_res", result, ref_mul(2'b11, 32'hF000_0000, 32'h0000_0100));
    last_res = ref_mul(2'b11, 32'hF000_0000, 32'h0000_0100);

    // Flush at cycle 10: idle next cycle, no done, result holds.
    @(negedge clk);
    launch(2'b00, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_res", result, last_res);
    count_dones(40, n);
    checkOutput("flush_nodone", 32'(n), 32'd0);
    checkOutput("flush_res_after", result, last_res);

    // Flush and start together: not accepted.
    start = 1'b1;
    flush = 1'b1;
    mulctl = 2'b00;
    rs1 = 32'd5;
    rs2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("fs_busy", 32'(busy), 32'd0);
    count_dones(40, n);
    checkOutput("fs_nodone", 32'(n), 32'd0);

    // Asynchronous reset mid-operation at cycle 15.
    launch(2'b00, 32'hFFFF_FFFF, 32'd3);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(mul_done), 32'd0);
    checkOutput("arst_res", result, 32'd0);
    last_res = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, n);
    checkOutput("arst_nodone", 32'(n), 32'd0);
    applyStimulus("post_rst", 2'b00, 32'd3, 32'd4);
    checkOutput("post_rst_const", last_res, 32'd12);

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      c = 2'(i % 4);
      a = $urandom;
      b = $urandom;
      if (i % 6 == 5) a = 32'h8000_0000;
      if (i % 7 == 3) b = 32'h8000_0000;
      applyStimulus($sformatf("rnd%0d", i), c, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
